ahb_interconnect_param: RTL
===========================

Name: ahb_interconnect_param

Overview:
- Parametrised AHB-Lite single-master interconnect: decodes the top SEL_W address bits into one-hot HSEL_o and muxes the selected slave's response back to the master.
- Registers the data-phase slave select, so the response mux follows AHB address/data pipelining and honours wait states.
- Includes a built-in default slave that returns a two-cycle ERROR response for unmapped addresses.
- Sits between the APB2AHB bridge master port and up to 2**SEL_W AHB slaves.

Parameters:
ADDR_W, 32, HADDR width
DATA_W, 32, HRDATA width
SEL_W, 4, number of HADDR MSBs decoded (region index = HADDR_i[ADDR_W-1 -: SEL_W])
NUM_SLV, 16, attached slaves, 1..2**SEL_W; region index >= NUM_SLV is unmapped and goes to the default slave

Ports:
HCLK_i  in  1  clock; all state updates on the rising edge
HRESET_i  in  1  synchronous, active-high reset
HADDR_i  in  ADDR_W  master address (address phase)
HTRANS_i  in  2  master transfer type; bit1=1 (NONSEQ/SEQ) means an active transfer
HRDATA_i  in  NUM_SLV*DATA_W  packed slave read data, slave k at [k*DATA_W +: DATA_W]
HRESP_i  in  NUM_SLV  slave responses, 0=OKAY, 1=ERROR
HREADYOUT_i  in  NUM_SLV  slave ready outputs
HSEL_o  out  NUM_SLV  one-hot slave select (address phase, combinational)
HRDATA_o  out  DATA_W  read data to master
HRESP_o  out  1  response to master
HREADY_o  out  1  ready to master and to all slaves' HREADY inputs

Behaviour:
- Reset: synchronous, active-high on HRESET_i.
  - Applied to: dp_active=0, dp_sel=0, dp_default=0, default-slave FSM=DS_IDLE.
  - While HRESET_i=1: HSEL_o=0, HREADY_o=1, HRESP_o=0, HRDATA_o=0.
  - Reset asserted mid-transfer (including mid-ERROR) aborts it; normal operation resumes the cycle after HRESET_i falls.
- Decode (combinational):
  - idx = HADDR_i[ADDR_W-1 -: SEL_W].
  - HSEL_o[idx]=1 only when HTRANS_i[1]=1 and idx<NUM_SLV; otherwise HSEL_o=0.
  - IDLE/BUSY cycles therefore never assert HSEL_o.
- Data-phase register: updated only on edges where HREADY_o=1.
  - dp_active <= HTRANS_i[1] && idx<NUM_SLV
  - dp_default <= HTRANS_i[1] && idx>=NUM_SLV
  - dp_sel <= idx
  - When HREADY_o=0, all three hold; the master's address is held per AHB, so a slave wait state stalls the pipeline.
- Response mux (combinational from registered state):
  - dp_active=1: HREADY_o=HREADYOUT_i[dp_sel], HRESP_o=HRESP_i[dp_sel], HRDATA_o=slave dp_sel data.
  - dp_default=1: HREADY_o/HRESP_o come from the default-slave FSM; HRDATA_o=0.
  - Neither: HREADY_o=1, HRESP_o=0, HRDATA_o=0 (zero-wait OKAY, covers IDLE/BUSY).
- Default-slave FSM states:
  - DS_IDLE: on HREADY_o=1 with an unmapped active transfer -> DS_ERR1.
  - DS_ERR1: drives HREADY_o=0, HRESP_o=1; -> DS_ERR2 unconditionally.
  - DS_ERR2: drives HREADY_o=1, HRESP_o=1. Next state is DS_ERR1 if another unmapped active transfer is presented this cycle, else DS_IDLE.
- Latency:
  - Mapped slave: response appears the cycle after its address phase; total cycles = 1 + slave wait states.
  - Unmapped address: exactly 2 data-phase cycles.
- Boundary cases:
  - Back-to-back mapped-to-unmapped, unmapped-to-mapped and slave-to-slave transfers switch the mux exactly at the HREADY_o=1 edge; no bubble is inserted.
  - A slave ERROR (two-cycle) is passed through unmodified.
  - NUM_SLV=2**SEL_W means there are no unmapped regions; the FSM is never entered.

Optional Feature:
- Macro AHB_ICN_ERRCNT_EN.
- Defined:
  - Adds output err_cnt_o (16 bits, reset 0).
  - Increments by 1 on each edge with HREADY_o=1 and HRESP_o=1, i.e. once per completed ERROR response from either a slave or the default slave.
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: HRESET_i=1 for 2 cycles during an active transfer -> HSEL_o=0, HREADY_o=1, HRESP_o=0, HRDATA_o=0; after release, first transfer decodes normally.
- Read HADDR_i=32'h3000_0010, HTRANS_i=NONSEQ, slave3 HRDATA=32'hDEAD_BEEF, zero wait -> HSEL_o=16'h0008 in the address cycle; next cycle HRDATA_o=32'hDEAD_BEEF, HREADY_o=1, HRESP_o=0.
- Slave 5 holds HREADYOUT=0 for 3 cycles while the next address is 32'h7000_0000 -> HREADY_o=0 for 3 cycles, dp_sel stays 5, then the slave-7 data phase follows with no gap.
- NUM_SLV=12, HADDR_i=32'hC000_0000, NONSEQ -> HSEL_o=0; data phase gives HREADY_o=0/HRESP_o=1, then HREADY_o=1/HRESP_o=1; with AHB_ICN_ERRCNT_EN, err_cnt_o goes 0->1.
- HTRANS_i=BUSY to an unmapped address -> no HSEL_o, OKAY response with zero wait, FSM stays DS_IDLE.
- Back-to-back unmapped NONSEQ presented during DS_ERR2 -> FSM goes ERR1 again, two full ERROR responses; with the macro, err_cnt_o=2; pre-loaded err_cnt_o=16'hFFFF stays at 16'hFFFF.

Source files
------------

// File: rtl/ahb_interconnect_param.sv
// ahb_interconnect_param: AHB-Lite single-master decoder/response mux with a built-in ERROR default slave; define AHB_ICN_ERRCNT_EN to add err_cnt_o
module ahb_interconnect_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int NUM_SLV = 16
) (
  input  logic                      HCLK_i,
  input  logic                      HRESET_i,
  input  logic [ADDR_W-1:0]         HADDR_i,
  input  logic [1:0]                HTRANS_i,
  input  logic [NUM_SLV*DATA_W-1:0] HRDATA_i,
  input  logic [NUM_SLV-1:0]        HRESP_i,
  input  logic [NUM_SLV-1:0]        HREADYOUT_i,
  output logic [NUM_SLV-1:0]        HSEL_o,
  output logic [DATA_W-1:0]         HRDATA_o,
  output logic                      HRESP_o,
  output logic                      HREADY_o
`ifdef AHB_ICN_ERRCNT_EN
  ,
  output logic [15:0]               err_cnt_o
`endif
);
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;
  localparam logic [SEL_W:0] NUM_L = (SEL_W+1)'(NUM_SLV);
  ds_t ds, ds_nxt;
  logic [SEL_W-1:0] idx, dp_sel;
  logic act, mapped, dp_active, dp_default;
  logic [DATA_W-1:0] slv_rd [NUM_SLV];
  logic unused_bits;
  assign unused_bits = ^{HADDR_i[ADDR_W-SEL_W-1:0], HTRANS_i[0]};
  assign idx = HADDR_i[ADDR_W-1 -: SEL_W];
  assign act = HTRANS_i[1];
  assign mapped = {1'b0, idx} < NUM_L;
  for (genvar i = 0; i < NUM_SLV; i++) begin : g_rd
    assign slv_rd[i] = HRDATA_i[i*DATA_W +: DATA_W];
  end
  // address-phase decode, data-phase response mux and default-slave next state; reset forces an idle OKAY
  always_comb begin
    HSEL_o   = (!HRESET_i && act && mapped) ? NUM_SLV'(1) << idx : '0;
    HREADY_o = HRESET_i ? 1'b1 : dp_active ? HREADYOUT_i[dp_sel] : dp_default ? ds != DS_ERR1 : 1'b1;
    HRESP_o  = !HRESET_i && (dp_active ? HRESP_i[dp_sel] : dp_default && ds != DS_IDLE);
    HRDATA_o = (!HRESET_i && dp_active) ? slv_rd[dp_sel] : '0;
    ds_nxt   = ds == DS_ERR1 ? DS_ERR2 : (HREADY_o && act && !mapped) ? DS_ERR1 : DS_IDLE;
  end
  // data-phase select advances only when the current transfer completes
  always_ff @(posedge HCLK_i) begin
    if (HRESET_i) begin
      ds         <= DS_IDLE;
      dp_active  <= 1'b0;
      dp_default <= 1'b0;
      dp_sel     <= '0;
    end else begin
      ds <= ds_nxt;
      if (HREADY_o) begin
        dp_active  <= act && mapped;
        dp_default <= act && !mapped;
        dp_sel     <= idx;
      end
    end
  end
`ifdef AHB_ICN_ERRCNT_EN
  // counts completed ERROR responses, saturating
  always_ff @(posedge HCLK_i) begin
    if (HRESET_i) err_cnt_o <= '0;
    else if (HREADY_o && HRESP_o && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
  end
`endif
endmodule
